// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order credit-limited fetches and
// buffers returned words with their PCs for decode over a valid/ready handshake.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   r_pc;
  logic [31:0]   r_pcq     [FIFO_DEPTH];
  logic [31:0]   r_buf_inst[FIFO_DEPTH];
  logic [31:0]   r_buf_pc  [FIFO_DEPTH];
  logic [AW-1:0] r_pcq_wr, r_pcq_rd, r_head, r_tail;
  logic [CW-1:0] r_count, r_inflight, r_drop;

  logic w_credit, w_acc, w_rsp, w_drop, w_push, w_pop;
  logic w_unused;

  always_comb begin
    w_credit = (32'(r_count) + 32'(r_inflight)) < FIFO_DEPTH;
    // Gated by rst_n so no request is presented while the core is held in reset.
    imem_req_valid = rst_n & ~redirect & w_credit;
    imem_addr      = r_pc;
    w_acc          = imem_req_valid & imem_req_ready;
    w_rsp          = imem_rsp_valid & (r_inflight != '0);
    w_drop         = w_rsp & (r_drop != '0);
    w_push         = w_rsp & (r_drop == '0);
    id_valid       = (r_count != '0);
    id_inst        = id_valid ? r_buf_inst[r_head] : 32'h0000_0013;
    id_pc          = id_valid ? r_buf_pc[r_head]   : '0;
    w_pop          = id_valid & id_ready;
    w_unused       = ^redirect_pc[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_pcq_wr   <= '0;
      r_pcq_rd   <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
    end else if (redirect) begin
      // Everything still in flight becomes stale; a response landing now is already one of them.
      r_pc       <= {redirect_pc[31:2], 2'b00};
      r_pcq_wr   <= '0;
      r_pcq_rd   <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_inflight <= r_inflight - CW'(w_rsp);
      r_drop     <= r_inflight - CW'(w_rsp);
    end else begin
      if (w_acc) begin
        r_pc     <= r_pc + 32'd4;
        r_pcq_wr <= r_pcq_wr + AW'(1);
      end
      if (w_push) begin
        r_pcq_rd <= r_pcq_rd + AW'(1);
        r_tail   <= r_tail + AW'(1);
      end
      if (w_pop) r_head <= r_head + AW'(1);
      if (w_drop) r_drop <= r_drop - CW'(1);
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      r_inflight <= r_inflight + CW'(w_acc) - CW'(w_rsp);
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) r_pcq[r_pcq_wr] <= r_pc;
    if (w_push && !redirect) begin
      r_buf_inst[r_tail] <= imem_rsp_data;
      r_buf_pc[r_tail]   <= r_pcq[r_pcq_rd];
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (r_inflight != '0));

endmodule
